// File: rtl/gomoku_move_judger_pkg.sv
// Shared constants and types for the gomoku move judger: result codes, sides,
// cell encodings, FSM states and the per-direction step delta table.
package gomoku_move_judger_pkg;

   localparam logic [1:0] JUDGER_INVALID = 2'd0;
   localparam logic [1:0] JUDGER_VALID   = 2'd1;
   localparam logic [1:0] JUDGER_WIN     = 2'd2;

   localparam logic SIDE_RED   = 1'b0;
   localparam logic SIDE_GREEN = 1'b1;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_RED   = 2'b01;
   localparam logic [1:0] CELL_GREEN = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_OCC_RD,
      S_OCC_EV,
      S_RAY_STEP,
      S_RAY_RD,
      S_RAY_EV,
      S_FIN,
      S_HOLD
   } judge_state_t;

   typedef struct packed {
      logic signed [1:0] dx;
      logic signed [1:0] dy;
   } delta_t;

   // Ray 1 walks the same line as ray 0 in the opposite direction.
   function automatic delta_t dir_delta(input logic [1:0] dir, input logic ray);
      delta_t d;
      d.dx = 2'sd0;
      d.dy = 2'sd0;
      case (dir)
         2'd0: begin d.dx = 2'sd1; d.dy = 2'sd0;  end
         2'd1: begin d.dx = 2'sd0; d.dy = 2'sd1;  end
         2'd2: begin d.dx = 2'sd1; d.dy = 2'sd1;  end
         default: begin d.dx = 2'sd1; d.dy = -2'sd1; end
      endcase
      if (ray) begin
         d.dx = -d.dx;
         d.dy = -d.dy;
      end
      return d;
   endfunction

endpackage

// File: rtl/gomoku_move_judger_if.sv
// Judge handshake plus board RAM read port between the game controller and the judger.
interface gomoku_move_judger_if #(
   parameter int EDGE_ADDR_BITS = 3,
   parameter int DATA_BITS      = 2
);
   logic                          en;
   logic                          color;
   logic [2*EDGE_ADDR_BITS-1:0]   pos;
   logic [2*EDGE_ADDR_BITS-1:0]   ram_rd_addr;
   logic [DATA_BITS-1:0]          ram_data;
   logic [1:0]                    result;
   logic                          done;

   modport master (
      output en, color, pos, ram_data,
      input  ram_rd_addr, result, done
   );

   modport slave (
      input  en, color, pos, ram_data,
      output ram_rd_addr, result, done
   );
endinterface

// File: rtl/gomoku_move_judger.sv
// Classifies a gomoku move as INVALID / VALID / WIN by reading the board RAM
// cell by cell and walking both rays of each of the four lines through the move.
module gomoku_move_judger
   import gomoku_move_judger_pkg::*;
#(
   parameter int EDGE_ADDR_BITS = 3,
   parameter int DATA_BITS      = 2,
   parameter int WIN_LEN        = 5
) (
   input logic                 clk,
   input logic                 rst_n,
   gomoku_move_judger_if.slave jif
);

   localparam int ADDR_BITS = 2 * EDGE_ADDR_BITS;
   localparam int CW        = EDGE_ADDR_BITS + 2;
   localparam int RUN_W     = $clog2(2 * WIN_LEN);
   localparam int K_W       = $clog2(WIN_LEN + 1);

   localparam logic [K_W-1:0]       K_LAST  = K_W'(WIN_LEN - 1);
   localparam logic [RUN_W-1:0]     RUN_WIN = RUN_W'(WIN_LEN);
   localparam logic [DATA_BITS-1:0] EMPTY   = DATA_BITS'(CELL_EMPTY);

   judge_state_t state_q, state_d;

   logic [ADDR_BITS-1:0] pos_q, pos_d;
   logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
   logic                 color_q, color_d;
   logic                 ray_q, ray_d;
   logic                 done_q, done_d;
   logic [1:0]           dir_q, dir_d;
   logic [1:0]           verdict_q, verdict_d;
   logic [1:0]           result_q, result_d;
   logic [RUN_W-1:0]     run_q, run_d, run_inc;
   logic [K_W-1:0]       k_q, k_d;

   delta_t                dd;
   logic signed [CW-1:0]  step_n, px, py, dxw, dyw, nx, ny;
   logic [ADDR_BITS-1:0]  next_addr;
   logic [DATA_BITS-1:0]  own_cell;
   logic                  off_board, ray_end_step, own_hit, occupied;
   logic                  run_won, hit_wins, end_to_fin;

   assign jif.ram_rd_addr = rd_addr_q;
   assign jif.result      = result_q;
   assign jif.done        = done_q;

   // Stepper: coordinates are widened and signed so a step past either edge
   // shows up as non-zero bits above the coordinate field instead of wrapping.
   always_comb begin
      dd        = dir_delta(dir_q, ray_q);
      step_n    = CW'(k_q) + CW'(1);
      px        = CW'(pos_q[EDGE_ADDR_BITS-1:0]);
      py        = CW'(pos_q[ADDR_BITS-1:EDGE_ADDR_BITS]);
      dxw       = $signed({{(CW-2){dd.dx[1]}}, dd.dx});
      dyw       = $signed({{(CW-2){dd.dy[1]}}, dd.dy});
      nx        = px + step_n * dxw;
      ny        = py + step_n * dyw;
      off_board = (nx[CW-1:EDGE_ADDR_BITS] != '0) || (ny[CW-1:EDGE_ADDR_BITS] != '0);
      next_addr = {ny[EDGE_ADDR_BITS-1:0], nx[EDGE_ADDR_BITS-1:0]};
      ray_end_step = off_board || (k_q == K_LAST);
      own_cell  = (color_q == SIDE_GREEN) ? DATA_BITS'(CELL_GREEN) : DATA_BITS'(CELL_RED);
      own_hit   = (jif.ram_data == own_cell);
      occupied  = (jif.ram_data != EMPTY);
      run_inc   = run_q + RUN_W'(1);
      run_won   = (run_q >= RUN_WIN);
      hit_wins  = (run_inc >= RUN_WIN);
      end_to_fin = ray_q && (run_won || (dir_q == 2'd3));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pos_q     <= '0;
         rd_addr_q <= '0;
         color_q   <= 1'b0;
         ray_q     <= 1'b0;
         done_q    <= 1'b0;
         dir_q     <= '0;
         verdict_q <= JUDGER_INVALID;
         result_q  <= JUDGER_INVALID;
         run_q     <= '0;
         k_q       <= '0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         rd_addr_q <= rd_addr_d;
         color_q   <= color_d;
         ray_q     <= ray_d;
         done_q    <= done_d;
         dir_q     <= dir_d;
         verdict_q <= verdict_d;
         result_q  <= result_d;
         run_q     <= run_d;
         k_q       <= k_d;
      end
   end

   // Dropping en anywhere inside the scan abandons the judgement.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (jif.en) state_d = S_OCC_RD;
         S_FIN:  state_d = S_HOLD;
         S_HOLD: if (!jif.en) state_d = S_IDLE;
         default: begin
            if (!jif.en) begin
               state_d = S_IDLE;
            end else begin
               case (state_q)
                  S_OCC_RD: state_d = S_OCC_EV;
                  S_OCC_EV: state_d = occupied ? S_FIN : S_RAY_STEP;
                  S_RAY_STEP: begin
                     if (ray_end_step) state_d = end_to_fin ? S_FIN : S_RAY_STEP;
                     else              state_d = S_RAY_RD;
                  end
                  S_RAY_RD: state_d = S_RAY_EV;
                  S_RAY_EV: begin
                     if (own_hit)         state_d = hit_wins ? S_FIN : S_RAY_STEP;
                     else if (end_to_fin) state_d = S_FIN;
                     else                 state_d = S_RAY_STEP;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
      endcase
   end

   always_comb begin
      logic take_end;
      take_end  = 1'b0;
      pos_d     = pos_q;
      rd_addr_d = rd_addr_q;
      color_d   = color_q;
      ray_d     = ray_q;
      done_d    = 1'b0;
      dir_d     = dir_q;
      verdict_d = verdict_q;
      result_d  = result_q;
      run_d     = run_q;
      k_d       = k_q;
      case (state_q)
         S_IDLE: begin
            if (jif.en) begin
               pos_d     = jif.pos;
               color_d   = jif.color;
               rd_addr_d = jif.pos;
            end
         end
         S_OCC_EV: begin
            if (jif.en) begin
               if (occupied) begin
                  verdict_d = JUDGER_INVALID;
               end else begin
                  run_d = RUN_W'(1);
                  dir_d = 2'd0;
                  ray_d = 1'b0;
                  k_d   = '0;
               end
            end
         end
         S_RAY_STEP: begin
            if (jif.en) begin
               if (ray_end_step) take_end  = 1'b1;
               else              rd_addr_d = next_addr;
            end
         end
         S_RAY_EV: begin
            if (jif.en) begin
               if (own_hit) begin
                  run_d = run_inc;
                  k_d   = k_q + K_W'(1);
                  if (hit_wins) verdict_d = JUDGER_WIN;
               end else begin
                  take_end = 1'b1;
               end
            end
         end
         S_FIN: begin
            done_d   = 1'b1;
            result_d = verdict_q;
         end
         default: ;
      endcase

      // End of a ray: flip to the opposite ray, or close the line and move on.
      if (take_end) begin
         if (!ray_q) begin
            ray_d = 1'b1;
            k_d   = '0;
         end else if (run_won) begin
            verdict_d = JUDGER_WIN;
         end else if (dir_q == 2'd3) begin
            verdict_d = JUDGER_VALID;
         end else begin
            dir_d = dir_q + 2'd1;
            ray_d = 1'b0;
            k_d   = '0;
            run_d = RUN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_gomoku_move_judger.sv
// Directed bench for gomoku_move_judger with a synchronous-read board RAM model.
module tb_gomoku_move_judger;
   import gomoku_move_judger_pkg::*;

   localparam int MAX_CYC = 200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] board [64];
   int n_checks = 0;
   int n_fail = 0;

   gomoku_move_judger_if #(.EDGE_ADDR_BITS(3), .DATA_BITS(2)) jif ();

   gomoku_move_judger #(.EDGE_ADDR_BITS(3), .DATA_BITS(2), .WIN_LEN(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .jif   (jif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) jif.ram_data <= board[jif.ram_rd_addr];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_board();
      for (int i = 0; i < 64; i++) board[i] = CELL_EMPTY;
   endtask

   task automatic put(input int y, input int x, input logic [1:0] c);
      board[y * 8 + x] = c;
   endtask

   // Runs one judgement; lat counts edges after the edge that samples en.
   task automatic judge(input int p, input logic c, output int lat,
                        output logic [1:0] res, output int pulses);
      lat = -1;
      res = 2'd3;
      pulses = 0;
      @(negedge clk);
      jif.pos   = 6'(p);
      jif.color = c;
      jif.en    = 1'b1;
      for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
         @(posedge clk);
         #1;
         if (jif.done) begin
            pulses++;
            if (lat < 0) begin
               lat = cyc;
               res = jif.result;
            end
         end
         if (lat >= 0 && cyc >= lat + 4) break;
      end
      @(negedge clk);
      jif.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (jif.done) pulses++;
      end
   endtask

   initial begin
      int lat;
      int pulses;
      logic [1:0] res;

      jif.en = 1'b0;
      jif.color = 1'b0;
      jif.pos = '0;
      clear_board();
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", int'(jif.done), 0);
      check("rst_result", int'(jif.result), int'(JUDGER_INVALID));
      check("rst_addr", int'(jif.ram_rd_addr), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // T1: occupied cell
      put(3, 3, CELL_RED);
      judge(27, SIDE_RED, lat, res, pulses);
      check("t1_lat", lat, 3);
      check("t1_res", int'(res), int'(JUDGER_INVALID));
      check("t1_pulses", pulses, 1);

      // T2: empty board from the corner; 17 edges traced by hand through all rays
      clear_board();
      judge(0, SIDE_RED, lat, res, pulses);
      check("t2a_res", int'(res), int'(JUDGER_VALID));
      check("t2a_pulses", pulses, 1);
      check("t2a_lat", lat, 17);
      judge(0, SIDE_RED, lat, res, pulses);
      check("t2b_res", int'(res), int'(JUDGER_VALID));
      check("t2b_pulses", pulses, 1);
      check("t2b_lat", lat, 17);

      // T3: horizontal four plus the move
      clear_board();
      for (int x = 0; x < 4; x++) put(2, x, CELL_RED);
      judge(2 * 8 + 4, SIDE_RED, lat, res, pulses);
      check("t3_red_res", int'(res), int'(JUDGER_WIN));
      judge(2 * 8 + 4, SIDE_GREEN, lat, res, pulses);
      check("t3_green_res", int'(res), int'(JUDGER_VALID));

      // T4: anti-diagonal joined from both sides
      clear_board();
      put(5, 1, CELL_GREEN);
      put(4, 2, CELL_GREEN);
      put(2, 4, CELL_GREEN);
      put(1, 5, CELL_GREEN);
      judge(3 * 8 + 3, SIDE_GREEN, lat, res, pulses);
      check("t4_res", int'(res), int'(JUDGER_WIN));
      check("t4_pulses", pulses, 1);

      // T5: no row wrap, and a blocked run
      clear_board();
      put(0, 6, CELL_RED);
      put(0, 7, CELL_RED);
      put(1, 0, CELL_RED);
      put(1, 1, CELL_RED);
      judge(1 * 8 + 2, SIDE_RED, lat, res, pulses);
      check("t5_wrap_res", int'(res), int'(JUDGER_VALID));
      clear_board();
      for (int x = 0; x < 4; x++) put(6, x, CELL_RED);
      put(6, 4, CELL_GREEN);
      judge(6 * 8 + 5, SIDE_RED, lat, res, pulses);
      check("t5_block_res", int'(res), int'(JUDGER_VALID));

      // Corner: vertical win ending at (7,7)
      clear_board();
      for (int y = 3; y < 7; y++) put(y, 7, CELL_RED);
      judge(63, SIDE_RED, lat, res, pulses);
      check("corner_res", int'(res), int'(JUDGER_WIN));

      // T6a: abort mid-scan keeps prior INVALID result
      clear_board();
      put(0, 0, CELL_GREEN);
      judge(0, SIDE_RED, lat, res, pulses);
      check("t6_prior_res", int'(res), int'(JUDGER_INVALID));
      clear_board();
      @(negedge clk);
      jif.pos = 6'd0;
      jif.color = SIDE_RED;
      jif.en = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      jif.en = 1'b0;
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (jif.done) pulses++;
      end
      check("t6_abort_pulses", pulses, 0);
      check("t6_abort_res", int'(jif.result), int'(JUDGER_INVALID));
      judge(0, SIDE_RED, lat, res, pulses);
      check("t6_rerun_lat", lat, 17);
      check("t6_rerun_res", int'(res), int'(JUDGER_VALID));

      // T6b: async reset mid-scan
      @(negedge clk);
      jif.pos = 6'd63;
      jif.color = SIDE_RED;
      jif.en = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("t6_addr_pre", int'(jif.ram_rd_addr), 63);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_rst_done", int'(jif.done), 0);
      check("t6_rst_result", int'(jif.result), int'(JUDGER_INVALID));
      check("t6_rst_addr", int'(jif.ram_rd_addr), 0);
      jif.en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
